// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline hazard controller:
//   - datapath widths (register index, forward select, counters)
//   - hazard FSM state encoding
//   - ALU operand forwarding-select constants
//   - packed bundle of pipeline sequencing controls and its canned values
//   - helper that decides whether a writeback stage can feed a source operand
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned FWD_W       = 2;
  localparam int unsigned WAIT_CNT_W  = 8;
  localparam int unsigned STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_e;

  // ALU operand source selects
  localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } pipe_ctrl_t;

  // Free-running pipeline: fetch and advance, nothing squashed
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b0,
    idex_bubble: 1'b0,
    pipe_hold:   1'b0
  };

  // Held in reset: nothing advances and both front stages are squashed
  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b1,
    idex_bubble: 1'b1,
    pipe_hold:   1'b0
  };

  // A stage forwards to a source only if it writes a real (non-zero) register
  function automatic logic writes_reg(input logic             we,
                                      input logic [REG_W-1:0] rd,
                                      input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// ---------------------------------------------------------------------------
// forward_unit
// Combinational operand-forwarding select for one ALU source operand.
// The younger MEM-stage result wins over the older WB-stage result; register
// zero is hard-wired and never forwarded.
// Ports:
//   mem_reg_write_i, mem_rd_i : MEM-stage writeback enable and destination
//   wb_reg_write_i,  wb_rd_i  : WB-stage writeback enable and destination
//   ex_rs_i                   : source register of the operand in EX
//   fwd_sel_c_o               : FWD_REG / FWD_WB / FWD_MEM (combinational)
// ---------------------------------------------------------------------------
module forward_unit
  import pipe_pkg::*;
(
  input  logic             mem_reg_write_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             wb_reg_write_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic [REG_W-1:0] ex_rs_i,
  output logic [FWD_W-1:0] fwd_sel_c_o
);

  // Priority select: MEM, then WB, else register file
  always_comb begin
    fwd_sel_c_o = FWD_REG;
    if (writes_reg(mem_reg_write_i, mem_rd_i, ex_rs_i)) begin
      fwd_sel_c_o = FWD_MEM;
    end else if (writes_reg(wb_reg_write_i, wb_rd_i, ex_rs_i)) begin
      fwd_sel_c_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for a 5-stage in-order pipeline.
// Resolves, in priority order: data-memory wait, taken branch, load-use,
// jump. Sequencing controls and forward selects are decoded in the same
// cycle from the FSM state and the current stage inputs. Also keeps a
// saturating count of PC-stall cycles and a sticky memory-timeout flag.
// Ports:
//   CLK, RST_N                        : clock, async active-low reset
//   ID_Rs, ID_Rt, ID_Jump             : ID-stage sources and jump decode
//   EX_Rs, EX_Rt, EX_MemRead,
//   EX_BrTaken                        : EX-stage sources, load, taken branch
//   MEM_RegWrite, MEM_Rd, MEM_Req,
//   DMEM_Ready                        : MEM-stage writeback and memory handshake
//   WB_RegWrite, WB_Rd                : WB-stage writeback
//   PC_Write, IFID_Write, IFID_Flush,
//   IDEX_Bubble, Pipe_Hold            : pipeline sequencing controls
//   Fwd_A, Fwd_B                      : ALU operand source selects
//   Mem_Timeout                       : sticky data-memory timeout flag
//   Stall_Count                       : saturating count of PC-stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [REG_W-1:0]       ID_Rs,
  input  logic [REG_W-1:0]       ID_Rt,
  input  logic                   ID_Jump,
  input  logic [REG_W-1:0]       EX_Rs,
  input  logic [REG_W-1:0]       EX_Rt,
  input  logic                   EX_MemRead,
  input  logic                   EX_BrTaken,
  input  logic                   MEM_RegWrite,
  input  logic [REG_W-1:0]       MEM_Rd,
  input  logic                   MEM_Req,
  input  logic                   DMEM_Ready,
  input  logic                   WB_RegWrite,
  input  logic [REG_W-1:0]       WB_Rd,
  output logic                   PC_Write,
  output logic                   IFID_Write,
  output logic                   IFID_Flush,
  output logic                   IDEX_Bubble,
  output logic                   Pipe_Hold,
  output logic [FWD_W-1:0]       Fwd_A,
  output logic [FWD_W-1:0]       Fwd_B,
  output logic                   Mem_Timeout,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  state_e                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  pipe_ctrl_t             ctrl_c;
  pipe_ctrl_t             ctrl_out_c;
  logic                   mem_wait_c;
  logic                   load_use_c;
  logic [FWD_W-1:0]       fwd_a_c;
  logic [FWD_W-1:0]       fwd_b_c;

  // Memory still busy with an outstanding request
  assign mem_wait_c = MEM_Req && !DMEM_Ready;

  // Load in EX feeding an ID source. The cycle after a load-use stall the
  // load has moved on and EX holds the inserted bubble, so the still-visible
  // EX fields are stale and must not re-trigger the stall.
  assign load_use_c = EX_MemRead && (EX_Rt != '0) &&
                      ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt)) &&
                      (state_q != ST_LOAD_STALL);

  // Hazard FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and sequencing controls, highest-priority event first
  always_comb begin
    state_d = ST_RUN;
    ctrl_c  = CTRL_RUN;
    if (mem_wait_c) begin
      state_d           = ST_MEM_WAIT;
      ctrl_c.pc_write   = 1'b0;
      ctrl_c.ifid_write = 1'b0;
      ctrl_c.pipe_hold  = 1'b1;
    end else if (EX_BrTaken) begin
      // Wrong-path instructions in IF/ID and ID/EX are squashed; a
      // coincident load-use is moot because its consumer is discarded.
      ctrl_c.ifid_flush  = 1'b1;
      ctrl_c.idex_bubble = 1'b1;
    end else if (load_use_c) begin
      state_d            = ST_LOAD_STALL;
      ctrl_c.pc_write    = 1'b0;
      ctrl_c.ifid_write  = 1'b0;
      ctrl_c.idex_bubble = 1'b1;
    end else if (ID_Jump) begin
      ctrl_c.ifid_flush = 1'b1;
    end
  end

  // Reset overrides the decode so the front of the pipe stays squashed
  always_comb begin
    ctrl_out_c = ctrl_c;
    if (!RST_N) begin
      ctrl_out_c = CTRL_RESET;
    end
  end

  assign PC_Write    = ctrl_out_c.pc_write;
  assign IFID_Write  = ctrl_out_c.ifid_write;
  assign IFID_Flush  = ctrl_out_c.ifid_flush;
  assign IDEX_Bubble = ctrl_out_c.idex_bubble;
  assign Pipe_Hold   = ctrl_out_c.pipe_hold;

  // Operand forwarding, one unit per ALU source
  forward_unit u_fwd_a (
    .mem_reg_write_i (MEM_RegWrite),
    .mem_rd_i        (MEM_Rd),
    .wb_reg_write_i  (WB_RegWrite),
    .wb_rd_i         (WB_Rd),
    .ex_rs_i         (EX_Rs),
    .fwd_sel_c_o     (fwd_a_c)
  );

  forward_unit u_fwd_b (
    .mem_reg_write_i (MEM_RegWrite),
    .mem_rd_i        (MEM_Rd),
    .wb_reg_write_i  (WB_RegWrite),
    .wb_rd_i         (WB_Rd),
    .ex_rs_i         (EX_Rt),
    .fwd_sel_c_o     (fwd_b_c)
  );

  assign Fwd_A = RST_N ? fwd_a_c : FWD_REG;
  assign Fwd_B = RST_N ? fwd_b_c : FWD_REG;

  // Consecutive wait-cycle counter (saturating) and sticky timeout
  always_comb begin
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    if (mem_wait_c) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q
                                      : wait_cnt_q + WAIT_CNT_W'(1);
      if (32'(wait_cnt_d) >= WAIT_LIMIT) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl_c.pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Counter and flag registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Mem_Timeout = timeout_q;
  assign Stall_Count = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, giving the maximum number of data-memory wait cycles before a timeout is flagged.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have inputs ID_Rs and ID_Rt, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have inputs EX_Rs and EX_Rt (5 bits each), EX_MemRead (1 bit) and EX_BrTaken (1 bit): EX-stage source registers, load flag, and resolved taken branch.
REQ-006 SHALL have inputs MEM_RegWrite (1 bit), MEM_Rd (5 bits), MEM_Req (1 bit) and DMEM_Ready (1 bit): MEM-stage writeback, data-memory access request, and memory-done handshake.
REQ-007 SHALL have inputs WB_RegWrite (1 bit) and WB_Rd (5 bits), plus ID_Jump (1 bit): jump decoded in ID.
REQ-008 SHALL have outputs PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble and Pipe_Hold, 1 bit each: pipeline sequencing controls.
REQ-009 SHALL have outputs Fwd_A and Fwd_B, 2 bits each: ALU operand source selects.
REQ-010 SHALL have outputs Mem_Timeout (1 bit, sticky) and Stall_Count (16 bits).

Function
REQ-011 SHALL implement FSM states RUN, LOAD_STALL and MEM_WAIT; all control outputs are decoded from current state plus current inputs in the same cycle.
REQ-012 SHALL apply event priority in this order: MEM_WAIT condition, then taken branch, then load-use, then jump.
REQ-013 SHALL treat MEM_Req=1 with DMEM_Ready=0 in any state as a memory wait: state goes to MEM_WAIT; PC_Write=0, IFID_Write=0, Pipe_Hold=1, IFID_Flush=0, IDEX_Bubble=0.
REQ-014 SHALL leave MEM_WAIT on the cycle DMEM_Ready=1: that cycle has Pipe_Hold=0 and normal decode; next state is RUN.
REQ-015 SHALL detect load-use as EX_MemRead=1, EX_Rt!=0 and (EX_Rt==ID_Rs or EX_Rt==ID_Rt), and respond with PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly one cycle (state LOAD_STALL, then RUN).
REQ-016 SHALL, on EX_BrTaken=1 (no memory wait), assert IFID_Flush=1 and IDEX_Bubble=1 with PC_Write=1; any coincident load-use stall is discarded.
REQ-017 SHALL, on ID_Jump=1 with no higher-priority event, assert IFID_Flush=1 only, with PC_Write=1.
REQ-018 SHALL, in RUN with no event, drive PC_Write=1, IFID_Write=1, and all other controls 0.
REQ-019 SHALL compute Fwd_A as follows: 2'b10 if MEM_RegWrite, MEM_Rd!=0 and MEM_Rd==EX_Rs; else 2'b01 if WB_RegWrite, WB_Rd!=0 and WB_Rd==EX_Rs; else 2'b00. MEM takes priority over WB.
REQ-020 SHALL compute Fwd_B identically to Fwd_A, using EX_Rt.
REQ-021 SHALL count consecutive MEM_WAIT cycles in an 8-bit counter and set Mem_Timeout when the count reaches WAIT_LIMIT; Mem_Timeout is cleared only by reset.
REQ-022 SHALL increment Stall_Count on each cycle with PC_Write=0 outside reset, saturating at 16'hFFFF.

Reset
REQ-023 SHALL, while RST_N=0, force state to RUN and clear the wait counter, Stall_Count and Mem_Timeout to 0.
REQ-024 SHALL, while RST_N=0, drive PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, Pipe_Hold=0 and Fwd_A=Fwd_B=2'b00.
REQ-025 SHALL abandon any in-progress stall or wait when reset is asserted, and start in RUN on the first clock after RST_N deasserts.

Structure
REQ-026 SHALL place the state encoding and the forwarding-select constants (FWD_REG=00, FWD_WB=01, FWD_MEM=10) in a shared package pipe_pkg.
REQ-027 SHALL implement forwarding as the combinational sub-module forward_unit, instantiated once per operand.

Verification
REQ-028 SHALL cover load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 -> exactly one cycle of PC_Write=0 and IDEX_Bubble=1, then RUN with PC_Write=1.
REQ-029 SHALL cover branch plus load-use in the same cycle: EX_BrTaken=1 with the REQ-028 conditions -> IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, and no stall cycle follows.
REQ-030 SHALL cover memory wait: MEM_Req=1 with DMEM_Ready=0 for 3 cycles, then 1 -> Pipe_Hold=1 for 3 cycles, and Stall_Count increases by 3.
REQ-031 SHALL cover forwarding priority: MEM_Rd=WB_Rd=EX_Rs=7 with both RegWrite=1 -> Fwd_A=10; MEM_Rd=0 -> Fwd_A=01; register 0 never forwards.
REQ-032 SHALL cover timeout: DMEM_Ready held 0 for 255 cycles -> Mem_Timeout=1 and stays 1 after DMEM_Ready=1; reset clears it.
REQ-033 SHALL cover reset mid-wait: RST_N=0 during MEM_WAIT -> outputs match REQ-024 immediately, and the FSM is in RUN after release.
